// File: rtl/samp_switch_pkg.sv
// samp_switch_pkg: shared types and defaults for the sampling switch sequencer.
// Holds the FSM state encoding and the default channel / delay widths.
package samp_switch_pkg;

   // Default number of switch channels (bit 0 = p-side, bit 1 = n-side).
   localparam int NCH_DEF   = 2;
   // Default width of the on/off delay fields, in clock cycles.
   localparam int DLY_W_DEF = 4;

   // Sequencer states. busy is high in every state except ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ON_WAIT  = 2'd1,
      ST_ON       = 2'd2,
      ST_OFF_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/samp_switch_seq_if.sv
// samp_switch_seq_if: signal bundle between the sampling sequencer and the
// switch sequencer. The master drives the sampling window and its timing
// settings; the slave (samp_switch_seq) returns the switch drive and status.
//
// Protocol: there is no valid/ready pair. seq_samp is a level; a rising
// edge opens a window and a falling edge closes it. samp_en and on_dly are
// only looked at in the cycle the rise is detected, and off_dly only in the
// cycle the fall is detected; they may change freely at any other time.
// All slave outputs come straight from flops.
interface samp_switch_seq_if
   import samp_switch_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DLY_W = DLY_W_DEF
);

   // Master -> slave
   logic             seq_samp;
   logic [NCH-1:0]   samp_en;
   logic [DLY_W-1:0] on_dly;
   logic [DLY_W-1:0] off_dly;

   // Slave -> master
   logic [NCH-1:0]   switch;
   logic             busy;
   logic             overrun;
   logic [15:0]      samp_cnt;

   // Slave -> observer: internal state for checkers and debug
   state_t           dbg_state;
   logic [DLY_W-1:0] dbg_cnt;

   modport master (
      output seq_samp, samp_en, on_dly, off_dly,
      input  switch, busy, overrun, samp_cnt, dbg_state, dbg_cnt
   );

   modport slave (
      input  seq_samp, samp_en, on_dly, off_dly,
      output switch, busy, overrun, samp_cnt, dbg_state, dbg_cnt
   );

endinterface

// File: rtl/samp_switch_dly_cnt.sv
// samp_switch_dly_cnt: loadable down-counter shared by the turn-on and
// turn-off delay phases of the switch sequencer.
// o_expire is high while the counter holds 1, i.e. in the last wait cycle,
// so the owner can leave its wait state on that edge.
module samp_switch_dly_cnt #(
   parameter int DLY_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [DLY_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic [DLY_W-1:0] o_value,
   output logic             o_expire
);

   logic [DLY_W-1:0] r_value;

   // Load has priority over decrement; the count parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_dec && (r_value != '0)) begin
         r_value <= r_value - DLY_W'(1);
      end
   end

   assign o_value  = r_value;
   assign o_expire = (r_value == DLY_W'(1));

endmodule

// File: rtl/samp_switch_seq.sv
// samp_switch_seq: drives per-channel sampling switches from a sequencer
// window signal. A rise of seq_samp opens a window: after on_dly cycles the
// enabled switches close; a fall starts the off_dly countdown, after which
// they open again. A fall before turn-on aborts the window.
// Optional feature: define SAMP_SWITCH_CNT_EN to get a 16-bit count of
// completed windows on samp_cnt; otherwise samp_cnt is tied to zero.
module samp_switch_seq
   import samp_switch_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DLY_W = DLY_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   samp_switch_seq_if.slave  bus
);

   state_t           r_state;
   logic             r_seq_q;
   logic             r_armed;
   logic [NCH-1:0]   r_en_q;
   logic [NCH-1:0]   r_switch;
   logic             r_busy;
   logic             r_overrun;

   logic             w_rise;
   logic             w_fall;
   logic             w_cnt_load;
   logic [DLY_W-1:0] w_cnt_val;
   logic             w_cnt_dec;
   logic [DLY_W-1:0] w_cnt_value;
   logic             w_cnt_expire;

   // r_armed stays low after reset until seq_samp has been seen low, so a
   // window already in progress when reset releases is never picked up.
   assign w_rise = bus.seq_samp & ~r_seq_q & r_armed;
   assign w_fall = ~bus.seq_samp & r_seq_q;

   // Delay counter control: load on the capture cycles, count down in waits.
   always_comb begin
      w_cnt_load = 1'b0;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = bus.on_dly;
            end
         end
         ST_ON_WAIT: begin
            if (w_fall) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = bus.off_dly;
            end else begin
               w_cnt_dec  = 1'b1;
            end
         end
         ST_ON: begin
            if (w_fall) begin
               w_cnt_load = 1'b1;
               w_cnt_val  = bus.off_dly;
            end
         end
         ST_OFF_WAIT: begin
            w_cnt_dec = 1'b1;
         end
         default: begin
            w_cnt_dec = 1'b0;
         end
      endcase
   end

   samp_switch_dly_cnt #(
      .DLY_W (DLY_W)
   ) u_dly_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_val),
      .i_dec      (w_cnt_dec),
      .o_value    (w_cnt_value),
      .o_expire   (w_cnt_expire)
   );

   // Window FSM; switch, busy and overrun are updated on the same edge as
   // the state so they always agree with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_seq_q   <= 1'b0;
         r_armed   <= 1'b0;
         r_en_q    <= '0;
         r_switch  <= '0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_seq_q <= bus.seq_samp;
         if (!bus.seq_samp) begin
            r_armed <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_en_q <= bus.samp_en;
                  r_busy <= 1'b1;
                  if (bus.on_dly == '0) begin
                     r_state  <= ST_ON;
                     r_switch <= bus.samp_en;
                  end else begin
                     r_state  <= ST_ON_WAIT;
                  end
               end
            end
            ST_ON_WAIT: begin
               // A fall before turn-on abandons the window entirely.
               if (w_fall) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_cnt_expire) begin
                  r_state  <= ST_ON;
                  r_switch <= r_en_q;
               end
            end
            ST_ON: begin
               if (w_fall) begin
                  if (bus.off_dly == '0) begin
                     r_state  <= ST_IDLE;
                     r_switch <= '0;
                     r_busy   <= 1'b0;
                  end else begin
                     r_state  <= ST_OFF_WAIT;
                  end
               end
            end
            ST_OFF_WAIT: begin
               // A new window cannot start before the switch has opened.
               if (w_rise) begin
                  r_overrun <= 1'b1;
               end
               if (w_cnt_expire) begin
                  r_state  <= ST_IDLE;
                  r_switch <= '0;
                  r_busy   <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_switch <= '0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

`ifdef SAMP_SWITCH_CNT_EN
   logic        w_win_done;
   logic [15:0] r_samp_cnt;

   assign w_win_done = ((r_state == ST_ON) && w_fall && (bus.off_dly == '0)) ||
                       ((r_state == ST_OFF_WAIT) && w_cnt_expire);

   // Completed-window counter; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_samp_cnt <= '0;
      end else if (w_win_done) begin
         r_samp_cnt <= r_samp_cnt + 16'd1;
      end
   end

   assign bus.samp_cnt = r_samp_cnt;
`else
   assign bus.samp_cnt = '0;
`endif

   assign bus.switch    = r_switch;
   assign bus.busy      = r_busy;
   assign bus.overrun   = r_overrun;
   assign bus.dbg_state = r_state;
   assign bus.dbg_cnt   = w_cnt_value;

endmodule

// File: tb/tb_samp_switch_seq.sv
// tb_samp_switch_seq: directed bench for samp_switch_seq. Two instances are
// used: a default 2-channel one and a 4-channel one for the wide-enable case.
// Outputs are sampled on the falling edge; inputs change right after it.
module tb_samp_switch_seq;
   import samp_switch_pkg::*;

`ifdef SAMP_SWITCH_CNT_EN
   localparam logic [15:0] CNT_EN = 16'd1;
`else
   localparam logic [15:0] CNT_EN = 16'd0;
`endif

   logic clk;
   logic rst_n;

   int total;
   int bad;
   logic [15:0] exp_cnt2;
   logic [15:0] exp_cnt4;

   samp_switch_seq_if #(.NCH(2), .DLY_W(4)) if2 ();
   samp_switch_seq_if #(.NCH(4), .DLY_W(4)) if4 ();

   samp_switch_seq #(.NCH(2), .DLY_W(4)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2)
   );

   samp_switch_seq #(.NCH(4), .DLY_W(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if4)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      rst_n        = 1'b0;
      if2.seq_samp = 1'b0;
      if2.samp_en  = 2'b00;
      if2.on_dly   = 4'd0;
      if2.off_dly  = 4'd0;
      if4.seq_samp = 1'b0;
      if4.samp_en  = 4'b0000;
      if4.on_dly   = 4'd0;
      if4.off_dly  = 4'd0;
      exp_cnt2     = 16'd0;
      exp_cnt4     = 16'd0;
      repeat (3) @(negedge clk);
      total++;
      if ({if2.switch, if2.busy, if2.overrun} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_out2: {sw,busy,ovr} got %b want %b", {if2.switch, if2.busy, if2.overrun}, 4'b0000);
      end
      total++;
      if (if2.samp_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_cnt2: got %0d want 0", if2.samp_cnt);
      end
      total++;
      if (if2.dbg_state !== ST_IDLE) begin
         bad++;
         $display("FAIL reset_state2: got %0d want %0d", if2.dbg_state, ST_IDLE);
      end
      total++;
      if ({if4.switch, if4.busy, if4.overrun} !== 6'b000000) begin
         bad++;
         $display("FAIL reset_out4: {sw,busy,ovr} got %b want %b", {if4.switch, if4.busy, if4.overrun}, 6'b000000);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // on_dly=0, off_dly=0: switch on at t+1, off at fall+1
   task automatic test_zero_dly();
      if2.on_dly   = 4'd0;
      if2.off_dly  = 4'd0;
      if2.samp_en  = 2'b11;
      if2.seq_samp = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== 4'b1110) begin
            bad++;
            $display("FAIL zero_dly c%0d: {sw,busy,ovr} got %b want %b", i, {if2.switch, if2.busy, if2.overrun}, 4'b1110);
         end
         if (i == 5) if2.seq_samp = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({if2.switch, if2.busy, if2.overrun} !== 4'b0000) begin
         bad++;
         $display("FAIL zero_dly_off: {sw,busy,ovr} got %b want %b", {if2.switch, if2.busy, if2.overrun}, 4'b0000);
      end
      exp_cnt2 = exp_cnt2 + CNT_EN;
      total++;
      if (if2.samp_cnt !== exp_cnt2) begin
         bad++;
         $display("FAIL zero_dly_cnt: got %0d want %0d", if2.samp_cnt, exp_cnt2);
      end
   endtask

   // on_dly=3, off_dly=2, samp_en=01; settings changed mid-window are ignored
   task automatic test_delay();
      logic [3:0] exp;
      if2.on_dly   = 4'd3;
      if2.off_dly  = 4'd2;
      if2.samp_en  = 2'b01;
      if2.seq_samp = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         exp = (i >= 4) ? 4'b0110 : 4'b0010;
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== exp) begin
            bad++;
            $display("FAIL delay c%0d: {sw,busy,ovr} got %b want %b", i, {if2.switch, if2.busy, if2.overrun}, exp);
         end
         if (i == 2) begin
            if2.on_dly  = 4'd1;
            if2.samp_en = 2'b11;
         end
         if (i == 10) if2.seq_samp = 1'b0;
      end
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         exp = (j <= 2) ? 4'b0110 : 4'b0000;
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== exp) begin
            bad++;
            $display("FAIL delay_off f+%0d: {sw,busy,ovr} got %b want %b", j, {if2.switch, if2.busy, if2.overrun}, exp);
         end
         if (j == 1) if2.off_dly = 4'd9;
      end
      exp_cnt2 = exp_cnt2 + CNT_EN;
      total++;
      if (if2.samp_cnt !== exp_cnt2) begin
         bad++;
         $display("FAIL delay_cnt: got %0d want %0d", if2.samp_cnt, exp_cnt2);
      end
   endtask

   // on_dly=6, window of 3 cycles: aborted, switch never closes
   task automatic test_abort();
      if2.on_dly   = 4'd6;
      if2.off_dly  = 4'd0;
      if2.samp_en  = 2'b11;
      if2.seq_samp = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== 4'b0010) begin
            bad++;
            $display("FAIL abort_wait c%0d: {sw,busy,ovr} got %b want %b", i, {if2.switch, if2.busy, if2.overrun}, 4'b0010);
         end
         if (i == 3) if2.seq_samp = 1'b0;
      end
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_idle f+%0d: {sw,busy,ovr} got %b want %b", j, {if2.switch, if2.busy, if2.overrun}, 4'b0000);
         end
      end
      total++;
      if (if2.samp_cnt !== exp_cnt2) begin
         bad++;
         $display("FAIL abort_cnt: got %0d want %0d", if2.samp_cnt, exp_cnt2);
      end
   endtask

   // samp_en all zero: FSM still runs (busy), switch stays open
   task automatic test_zero_en();
      if2.on_dly   = 4'd0;
      if2.off_dly  = 4'd1;
      if2.samp_en  = 2'b00;
      if2.seq_samp = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== ((i <= 3) ? 4'b0010 : 4'b0000)) begin
            bad++;
            $display("FAIL zero_en c%0d: {sw,busy,ovr} got %b want %b", i, {if2.switch, if2.busy, if2.overrun}, ((i <= 3) ? 4'b0010 : 4'b0000));
         end
         if (i == 2) if2.seq_samp = 1'b0;
      end
      exp_cnt2 = exp_cnt2 + CNT_EN;
      total++;
      if (if2.samp_cnt !== exp_cnt2) begin
         bad++;
         $display("FAIL zero_en_cnt: got %0d want %0d", if2.samp_cnt, exp_cnt2);
      end
   endtask

   // off_dly=5, new rise 2 cycles after fall: overrun, no second window
   task automatic test_overrun();
      logic [3:0] exp;
      if2.on_dly   = 4'd0;
      if2.off_dly  = 4'd5;
      if2.samp_en  = 2'b10;
      if2.seq_samp = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== 4'b1010) begin
            bad++;
            $display("FAIL ovr_on c%0d: {sw,busy,ovr} got %b want %b", i, {if2.switch, if2.busy, if2.overrun}, 4'b1010);
         end
         if (i == 3) if2.seq_samp = 1'b0;
      end
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         exp = {(j <= 5) ? 2'b10 : 2'b00, (j <= 5), (j >= 3)};
         total++;
         if ({if2.switch, if2.busy, if2.overrun} !== exp) begin
            bad++;
            $display("FAIL ovr f+%0d: {sw,busy,ovr} got %b want %b", j, {if2.switch, if2.busy, if2.overrun}, exp);
         end
         if (j == 2) if2.seq_samp = 1'b1;
      end
      exp_cnt2 = exp_cnt2 + CNT_EN;
      total++;
      if (if2.samp_cnt !== exp_cnt2) begin
         bad++;
         $display("FAIL ovr_cnt: got %0d want %0d", if2.samp_cnt, exp_cnt2);
      end
      if2.seq_samp = 1'b0;
      @(negedge clk);
   endtask

   // Reset while ON with seq_samp held high; re-arm only after a low
   task automatic test_reset_mid();
      if2.on_dly   = 4'd0;
      if2.off_dly  = 4'd0;
      if2.samp_en  = 2'b11;
      if2.seq_samp = 1'b1;
      @(negedge clk);
      total++;
      if ({if2.switch, if2.busy, if2.overrun} !== 4'b1111) begin
         bad++;
         $display("FAIL rstmid_on: {sw,busy,ovr} got %b want %b", {if2.switch, if2.busy, if2.overrun}, 4'b1111);
      end
      rst_n = 1'b0;
      @(negedge clk);
      exp_cnt2 = 16'd0;
      exp_cnt4 = 16'd0;
      total++;
      if ({if2.switch, if2.busy, if2.overrun, if2.samp_cnt} !== 20'h0) begin
         bad++;
         $display("FAIL rstmid_rst: {sw,busy,ovr,cnt} got %h want %h", {if2.switch, if2.busy, if2.overrun, if2.samp_cnt}, 20'h0);
      end
      total++;
      if (if2.dbg_state !== ST_IDLE) begin
         bad++;
         $display("FAIL rstmid_state: got %0d want %0d", if2.dbg_state, ST_IDLE);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if ({if2.switch, if2.busy} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_held c%0d: {sw,busy} got %b want %b", i, {if2.switch, if2.busy}, 3'b000);
         end
      end
      if2.seq_samp = 1'b0;
      @(negedge clk);
      if2.seq_samp = 1'b1;
      @(negedge clk);
      total++;
      if ({if2.switch, if2.busy, if2.overrun} !== 4'b1110) begin
         bad++;
         $display("FAIL rstmid_rearm: {sw,busy,ovr} got %b want %b", {if2.switch, if2.busy, if2.overrun}, 4'b1110);
      end
      if2.seq_samp = 1'b0;
      @(negedge clk);
      exp_cnt2 = exp_cnt2 + CNT_EN;
      total++;
      if ({if2.switch, if2.busy, if2.samp_cnt} !== {3'b000, exp_cnt2}) begin
         bad++;
         $display("FAIL rstmid_close: {sw,busy,cnt} got %h want %h", {if2.switch, if2.busy, if2.samp_cnt}, {3'b000, exp_cnt2});
      end
   endtask

   // NCH=4: samp_en changed mid-window does not affect the switch
   task automatic test_wide();
      logic [5:0] exp;
      if4.on_dly   = 4'd1;
      if4.off_dly  = 4'd1;
      if4.samp_en  = 4'b1010;
      if4.seq_samp = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1)      exp = 6'b0000_1_0;
         else if (i <= 7) exp = 6'b1010_1_0;
         else             exp = 6'b0000_0_0;
         total++;
         if ({if4.switch, if4.busy, if4.overrun} !== exp) begin
            bad++;
            $display("FAIL wide c%0d: {sw,busy,ovr} got %b want %b", i, {if4.switch, if4.busy, if4.overrun}, exp);
         end
         if (i == 1) if4.samp_en  = 4'b0101;
         if (i == 6) if4.seq_samp = 1'b0;
      end
      exp_cnt4 = exp_cnt4 + CNT_EN;
      total++;
      if (if4.samp_cnt !== exp_cnt4) begin
         bad++;
         $display("FAIL wide_cnt: got %0d want %0d", if4.samp_cnt, exp_cnt4);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_zero_dly();
      test_delay();
      test_abort();
      test_zero_en();
      test_overrun();
      test_reset_mid();
      test_wide();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
